// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and chunk-geometry helpers for the chunked subtractor
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor cell (x - y - bi)
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - multi-cycle a - b - bin, CHUNK bits per clock with a registered borrow
module chunked_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
  localparam int IW = idx_width(NUM_CHUNKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHUNKS - 1);

  state_t           state_q, state_d;
  logic             init_q;
  logic [IW-1:0]    idx_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q, b_q, work_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q, zero_q, ovf_q;

  logic [CHUNK-1:0] x_c, y_c, diff_c;
  logic [CHUNK:0]   bchain;
  logic [WIDTH-1:0] full_res;
  logic             accept, last_edge;

  assign x_c       = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign y_c       = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign bchain[0] = borrow_q;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    full_subtractor u_fs (
      .x   (x_c[i]),
      .y   (y_c[i]),
      .bi  (bchain[i]),
      .diff(diff_c[i]),
      .bo  (bchain[i+1])
    );
  end

  // Work register with the current chunk merged in; only published on the last chunk.
  always_comb begin
    full_res = work_q;
    full_res[int'(idx_q)*CHUNK +: CHUNK] = diff_c;
  end

  assign accept    = (state_q == IDLE) && init_q && start_valid;
  assign last_edge = (state_q == BUSY) && (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_edge) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      init_q   <= 1'b0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (accept) begin
        a_q      <= a;
        b_q      <= b;
        borrow_q <= bin;
        idx_q    <= '0;
      end else if (state_q == BUSY) begin
        work_q   <= full_res;
        borrow_q <= bchain[CHUNK];
        idx_q    <= idx_q + 1'b1;
        if (last_edge) begin
          d_q    <= full_res;
          bout_q <= bchain[CHUNK];
          zero_q <= (full_res == '0);
          ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (full_res[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign start_ready = init_q && (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign d           = d_q;
  assign bout        = bout_q;
  assign zero        = zero_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// tb/tb_chunked_subtractor.sv - directed self-checking bench for chunked_subtractor
module tb_chunked_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] d;
  logic        bout, zero, ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chunked_subtractor #(.WIDTH(32), .CHUNK(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .d          (d),
    .bout       (bout),
    .zero       (zero),
    .ovf        (ovf)
  );

  // Waits for start_ready, presents operands for one accept edge, then counts
  // cycles until res_valid (0 means it never came within the budget).
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic bv_in,
                        output int lat);
    int w;
    w = 0;
    while (start_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    a = av; b = bv; bin = bv_in; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; bin = ~bv_in;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({start_ready, res_valid, bout, zero, ovf} !== 5'b0 || d !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got sr=%b rv=%b d=%h bo=%b z=%b o=%b, want all 0",
               start_ready, res_valid, d, bout, zero, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got sr=%b rv=%b, want sr=1 rv=0", start_ready, res_valid);
    end
  endtask

  task automatic test_basic();
    int lat;
    launch(32'd5, 32'd3, 1'b0, lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL basic_latency: got %0d cycles, want 4", lat);
    end
    total++;
    if (d !== 32'h2 || bout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0 || start_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_5m3: got d=%h bo=%b z=%b o=%b sr=%b, want d=00000002 0 0 0 sr=0",
               d, bout, zero, ovf, start_ready);
    end
    handshake();
    total++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || d !== 32'h2) begin
      bad++;
      $display("FAIL basic_retire: got rv=%b sr=%b d=%h, want rv=0 sr=1 d=00000002",
               res_valid, start_ready, d);
    end
  endtask

  task automatic test_borrow_chain();
    int lat;
    launch(32'h0, 32'h1, 1'b0, lat);
    total++;
    if (lat !== 4 || d !== 32'hFFFF_FFFF || bout !== 1'b1 || zero !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL borrow_all: got lat=%0d d=%h bo=%b z=%b o=%b, want 4 ffffffff 1 0 0",
               lat, d, bout, zero, ovf);
    end
    handshake();
    launch(32'h0000_0100, 32'h0000_0001, 1'b0, lat);
    total++;
    if (d !== 32'h0000_00FF || bout !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL borrow_chunk01: got d=%h bo=%b z=%b, want 000000ff 0 0", d, bout, zero);
    end
    handshake();
  endtask

  task automatic test_flags();
    int lat;
    launch(32'h8000_0000, 32'h1, 1'b0, lat);
    total++;
    if (d !== 32'h7FFF_FFFF || bout !== 1'b0 || ovf !== 1'b1 || zero !== 1'b0) begin
      bad++;
      $display("FAIL flags_ovf: got d=%h bo=%b o=%b z=%b, want 7fffffff 0 1 0", d, bout, ovf, zero);
    end
    handshake();
    launch(32'h1234_5678, 32'h1234_5677, 1'b1, lat);
    total++;
    if (d !== 32'h0 || zero !== 1'b1 || bout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL flags_zero: got d=%h z=%b bo=%b o=%b, want 00000000 1 0 0", d, zero, bout, ovf);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    int errs;
    launch(32'h0000_1000, 32'h0000_0FFF, 1'b0, lat);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      a = 32'd100 + i; b = 32'd1; start_valid = 1'b1;
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || d !== 32'h1 ||
          bout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) errs++;
    end
    start_valid = 1'b0;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL hold_stable: got %0d unstable cycles d=%h rv=%b sr=%b, want 0 (d=00000001 rv=1 sr=0)",
               errs, d, res_valid, start_ready);
    end
    handshake();
    total++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || d !== 32'h1) begin
      bad++;
      $display("FAIL hold_release: got rv=%b sr=%b d=%h, want 0 1 00000001", res_valid, start_ready, d);
    end
    launch(32'd1000, 32'd1, 1'b1, lat);
    total++;
    if (lat !== 4 || d !== 32'd998 || bout !== 1'b0) begin
      bad++;
      $display("FAIL hold_next_op: got lat=%0d d=%h bo=%b, want 4 000003e6 0", lat, d, bout);
    end
    handshake();
  endtask

  task automatic test_reset_abort();
    int lat;
    int spurious;
    launch(32'd9, 32'd9, 1'b0, lat);
    handshake();
    a = 32'd1; b = 32'd2; bin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({start_ready, res_valid, bout, zero, ovf} !== 5'b0 || d !== 32'h0) begin
      bad++;
      $display("FAIL abort_async: got sr=%b rv=%b d=%h bo=%b z=%b o=%b, want all 0",
               start_ready, res_valid, d, bout, zero, ovf);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0) spurious++;
    end
    total++;
    if (spurious != 0) begin
      bad++;
      $display("FAIL abort_spurious: got %0d res_valid cycles, want 0", spurious);
    end
    launch(32'd7, 32'd2, 1'b0, lat);
    total++;
    if (lat !== 4 || d !== 32'd5 || bout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL abort_next_op: got lat=%0d d=%h bo=%b z=%b o=%b, want 4 00000005 0 0 0",
               lat, d, bout, zero, ovf);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_chain();
    test_flags();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chunked_subtractor.md
Name: chunked_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor computing d = a - b - bin, CHUNK bits per clock, with a registered inter-chunk borrow.
- Operand and result use valid/ready handshakes. Status flags (borrow-out, zero, signed overflow) are registered.
- Serves as the arithmetic complement to the team's ripple-carry adders in the datapath. It trades latency for a short borrow chain per cycle.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits processed per cycle. Must divide WIDTH; NUM_CHUNKS = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  operands present on a, b, bin.
- start_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- res_valid  output  1  result and flags valid.
- res_ready  input  1  consumer accepts result.
- d  output  WIDTH  difference, a - b - bin mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- zero  output  1  d == 0.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and d[MSB] != a[MSB].

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, chunk index=0, borrow reg=0, operand regs=0. Outputs d=0, bout=0, zero=0, ovf=0, res_valid=0, start_ready=0 during reset. start_ready=1 from the first edge after release.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start_ready=1, res_valid=0.
  - On start_valid && start_ready at an edge: latch a, b; borrow reg=bin; index=0; go to BUSY.
- BUSY:
  - start_ready=0.
  - Each edge: compute chunk[index] = a_chunk - b_chunk - borrow reg. Write it into the result reg slice; borrow reg = chunk borrow-out; index++.
  - Chunk 0 is the LSBs.
  - On the edge processing chunk NUM_CHUNKS-1: go to DONE. On that same edge, register bout = final borrow, zero = (full result == 0), ovf per the formula above.
- DONE:
  - res_valid=1, start_ready=0.
  - d, bout, zero, ovf are stable while res_valid && !res_ready.
  - On res_valid && res_ready: go to IDLE.
- Latency: accept edge E; res_valid is high in the cycle following edge E+NUM_CHUNKS (4 cycles with defaults). Throughput is one op per NUM_CHUNKS+2 cycles minimum.
- Output retention:
  - d and the flags keep the last result after the DONE->IDLE handshake and while the next op is BUSY.
  - They update only on the final-chunk edge, so partial results are never visible.
- start_valid outside IDLE is ignored; operands are not latched.
- a, b, bin may change after the accept edge without effect.
- Reset mid-BUSY or mid-DONE aborts the op; all outputs are at reset values. No spurious res_valid after release.
- res_ready high in IDLE or BUSY has no effect.
- Bit-cell equations: diff = x ^ y ^ bi; bo = (~x & y) | (~(x ^ y) & bi).

Decomposition:
- Shared package (arith_pkg):
  - state enum {IDLE, BUSY, DONE}.
  - function/constant for NUM_CHUNKS and index width clog2(NUM_CHUNKS).
- Sub-module: full_subtractor (x, y, bi -> diff, bo).
  - Instantiated CHUNK times as a rippled chain forming the per-cycle chunk subtractor.
  - Control FSM, operand/result registers and flags live in chunked_subtractor.

Test Plan:
1. a=5, b=3, bin=0 -> d=0x00000002, bout=0, zero=0, ovf=0. res_valid rises exactly 4 cycles after the accept edge.
2. a=0, b=1, bin=0 -> d=0xFFFFFFFF, bout=1, zero=0, ovf=0. Borrow propagates through all 4 chunks.
3. a=0x80000000, b=1, bin=0 -> d=0x7FFFFFFF, bout=0, ovf=1. Also a=0x12345678, b=0x12345677, bin=1 -> d=0, zero=1, bout=0.
4. a=0x00000100, b=0x00000001 -> d=0x000000FF, bout=0. Exercises the chunk0->chunk1 registered borrow.
5. Hold res_ready=0 for 10 cycles in DONE while pulsing start_valid with new operands -> d/flags stable, start_ready=0, new operands ignored. Release res_ready -> IDLE, start_ready=1. Next op returns correct results.
6. Assert rst_n low 2 cycles into BUSY -> all outputs 0 immediately (async), no res_valid afterwards. A new op 7-2 after release -> d=5.
